// File: rtl/parity_word_decoder.sv
// parity_word_decoder
//   Receive side of the 7-to-8 bit majority-bit link code. Strips the check
//   bit at position 4 of each coded word, recomputes the expected check bit
//   from the payload and flags a mismatch. One registered output entry sits
//   between the link receiver and the payload consumer (valid/ready on both
//   sides, full throughput, no skid buffer). Saturating word/error counters
//   support link-quality monitoring.
//
// Parameters:
//   CNT_W         width of word_count / err_count (saturating)
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous reset, active-high
//   in_valid      in_word/in_control valid
//   in_ready      decoder can accept a word this cycle
//   in_word       coded word {d[6:4], chk, d[3:0]}
//   in_control    sender mode: 0 = zero-majority, 1 = one-majority
//   out_valid     out_data/out_error valid
//   out_ready     consumer accepts output this cycle
//   out_data      recovered payload
//   out_error     received check bit differed from expected
//   word_count    words accepted since reset/clear
//   err_count     accepted words with a check-bit mismatch
//   clear_counts  synchronous clear of both counters
//
// Build option:
//   DECODER_DROP_ERR_EN  when defined, words with a check-bit mismatch are
//                        counted but not forwarded to the output.

module parity_word_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_word,
  input  logic             in_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_data,
  output logic             out_error,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_count,
  input  logic             clear_counts
);

  logic [6:0]       dec_data;
  logic [2:0]       ones;
  logic             exp_chk;
  logic             dec_err;
  logic             accept;
  logic             load;
  logic [CNT_W-1:0] word_base;
  logic [CNT_W-1:0] err_base;
  logic [CNT_W-1:0] word_next;
  logic [CNT_W-1:0] err_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // d[6] (in_word[7]) is deliberately left out of the majority count.
  always_comb begin
    dec_data = {in_word[7:5], in_word[3:0]};
    ones = {2'b00, in_word[6]} + {2'b00, in_word[5]} + {2'b00, in_word[3]}
         + {2'b00, in_word[2]} + {2'b00, in_word[1]} + {2'b00, in_word[0]};
    // A 3/3 tie never sets the check bit in either mode.
    if (in_control) exp_chk = (ones >= 3'd4);
    else            exp_chk = (ones <= 3'd2);
    dec_err = (in_word[4] != exp_chk);
  end

`ifdef DECODER_DROP_ERR_EN
  assign load = accept && !dec_err;
`else
  assign load = accept;
`endif

  // Clear takes effect first so a same-cycle accept restarts the count.
  always_comb begin
    word_base = clear_counts ? '0 : word_count;
    err_base  = clear_counts ? '0 : err_count;
    word_next = word_base;
    err_next  = err_base;
    if (accept && (word_base != '1)) word_next = word_base + 1'b1;
    if (accept && dec_err && (err_base != '1)) err_next = err_base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_error  <= 1'b0;
      word_count <= '0;
      err_count  <= '0;
    end else begin
      word_count <= word_next;
      err_count  <= err_next;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= dec_data;
        out_error <= dec_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parity_word_decoder.sv
// Directed-vector bench for parity_word_decoder (built with CNT_W=4 so the
// counter saturation boundary is reachable in a few cycles).
module tb_parity_word_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_word;
  logic       in_control;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic       out_error;
  logic [3:0] word_count;
  logic [3:0] err_count;
  logic       clear_counts;

  int tests = 0;
  int fails = 0;

`ifdef DECODER_DROP_ERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  always #5 clk = ~clk;

  parity_word_decoder #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_control(in_control), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_error(out_error),
    .word_count(word_count), .err_count(err_count), .clear_counts(clear_counts)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_word = 8'h7F; in_control = 1'b1;
    out_ready = 1'b1; clear_counts = 1'b0;
    step(); step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (out_data !== 7'h00) begin fails++; $display("FAIL reset_out_data got %h want 00", out_data); end
    tests++; if (out_error !== 1'b0) begin fails++; $display("FAIL reset_out_error got %b want 0", out_error); end
    tests++; if (word_count !== 4'd0) begin fails++; $display("FAIL reset_word_count got %0d want 0", word_count); end
    tests++; if (err_count !== 4'd0) begin fails++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_clean();
    in_valid = 1'b1; in_word = 8'h10; in_control = 1'b0;
    step();
    tests++; if ({out_valid, out_data, out_error} !== {1'b1, 7'h00, 1'b0}) begin
      fails++; $display("FAIL clean_10 got v=%b d=%h e=%b want v=1 d=00 e=0", out_valid, out_data, out_error); end
    in_word = 8'h7F; in_control = 1'b1;
    step();
    tests++; if ({out_valid, out_data, out_error} !== {1'b1, 7'h3F, 1'b0}) begin
      fails++; $display("FAIL clean_7F got v=%b d=%h e=%b want v=1 d=3f e=0", out_valid, out_data, out_error); end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clean_drain got %b want 0", out_valid); end
    tests++; if (out_data !== 7'h3F) begin fails++; $display("FAIL clean_hold_data got %h want 3f", out_data); end
    tests++; if (word_count !== 4'd2) begin fails++; $display("FAIL clean_word_count got %0d want 2", word_count); end
    tests++; if (err_count !== 4'd0) begin fails++; $display("FAIL clean_err_count got %0d want 0", err_count); end
  endtask

  task automatic test_errors();
    logic [7:0] w   [6] = '{8'h00, 8'h07, 8'h07, 8'h17, 8'h17, 8'h90};
    logic       c   [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic [6:0] d   [6] = '{7'h00, 7'h07, 7'h07, 7'h07, 7'h07, 7'h40};
    logic       e   [6] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    clear_counts = 1'b1; step(); clear_counts = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_word = w[i]; in_control = c[i];
      step();
      if (DROP && e[i]) begin
        tests++; if (out_valid !== 1'b0) begin
          fails++; $display("FAIL err_vec%0d_dropped got v=%b want v=0", i, out_valid); end
      end else begin
        tests++; if ({out_valid, out_data, out_error} !== {1'b1, d[i], e[i]}) begin
          fails++; $display("FAIL err_vec%0d got v=%b d=%h e=%b want v=1 d=%h e=%b",
                            i, out_valid, out_data, out_error, d[i], e[i]); end
      end
    end
    in_valid = 1'b0;
    step();
    tests++; if (word_count !== 4'd6) begin fails++; $display("FAIL err_word_count got %0d want 6", word_count); end
    tests++; if (err_count !== 4'd3) begin fails++; $display("FAIL err_err_count got %0d want 3", err_count); end
  endtask

  task automatic test_backpressure();
    clear_counts = 1'b1; step(); clear_counts = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_word = 8'h10; in_control = 1'b0;
    step();
    tests++; if ({out_valid, out_data} !== {1'b1, 7'h00}) begin
      fails++; $display("FAIL bp_first got v=%b d=%h want v=1 d=00", out_valid, out_data); end
    in_word = 8'h7F; in_control = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
      step();
      tests++; if ({out_valid, out_data, out_error} !== {1'b1, 7'h00, 1'b0}) begin
        fails++; $display("FAIL bp_hold%0d got v=%b d=%h e=%b want v=1 d=00 e=0", i, out_valid, out_data, out_error); end
    end
    tests++; if (word_count !== 4'd1) begin fails++; $display("FAIL bp_stall_count got %0d want 1", word_count); end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    step();
    tests++; if ({out_valid, out_data} !== {1'b1, 7'h3F}) begin
      fails++; $display("FAIL bp_second got v=%b d=%h want v=1 d=3f", out_valid, out_data); end
    in_word = 8'h90; in_control = 1'b0;
    step();
    tests++; if ({out_valid, out_data} !== {1'b1, 7'h40}) begin
      fails++; $display("FAIL bp_third got v=%b d=%h want v=1 d=40", out_valid, out_data); end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", out_valid); end
    tests++; if (word_count !== 4'd3) begin fails++; $display("FAIL bp_word_count got %0d want 3", word_count); end
  endtask

  task automatic test_saturation();
    clear_counts = 1'b1; step(); clear_counts = 1'b0;
    tests++; if ({word_count, err_count} !== 8'h00) begin
      fails++; $display("FAIL sat_clear got w=%0d e=%0d want 0 0", word_count, err_count); end
    in_valid = 1'b1; in_word = 8'h00; in_control = 1'b0;
    for (int i = 0; i < 17; i++) step();
    in_valid = 1'b0;
    step();
    tests++; if (err_count !== 4'd15) begin fails++; $display("FAIL sat_err_count got %0d want 15", err_count); end
    tests++; if (word_count !== 4'd15) begin fails++; $display("FAIL sat_word_count got %0d want 15", word_count); end
    clear_counts = 1'b1; in_valid = 1'b1; in_word = 8'h00; in_control = 1'b0;
    step();
    clear_counts = 1'b0; in_valid = 1'b0;
    tests++; if (word_count !== 4'd1) begin fails++; $display("FAIL clr_acc_word_count got %0d want 1", word_count); end
    tests++; if (err_count !== 4'd1) begin fails++; $display("FAIL clr_acc_err_count got %0d want 1", err_count); end
    step();
  endtask

  task automatic test_back_to_back_drop();
    // Mixed clean/errored stream: errored word is forwarded or dropped by build.
    clear_counts = 1'b1; step(); clear_counts = 1'b0;
    in_valid = 1'b1; in_word = 8'h10; in_control = 1'b0;
    step();
    tests++; if ({out_valid, out_data} !== {1'b1, 7'h00}) begin
      fails++; $display("FAIL b2b_w0 got v=%b d=%h want v=1 d=00", out_valid, out_data); end
    in_word = 8'h00;
    step();
    tests++; if (out_valid !== !DROP) begin
      fails++; $display("FAIL b2b_w1 got v=%b want v=%b", out_valid, !DROP); end
    in_word = 8'h7F; in_control = 1'b1;
    step();
    tests++; if ({out_valid, out_data, out_error} !== {1'b1, 7'h3F, 1'b0}) begin
      fails++; $display("FAIL b2b_w2 got v=%b d=%h e=%b want v=1 d=3f e=0", out_valid, out_data, out_error); end
    in_valid = 1'b0;
    step();
    tests++; if ({word_count, err_count} !== {4'd3, 4'd1}) begin
      fails++; $display("FAIL b2b_counts got w=%0d e=%0d want 3 1", word_count, err_count); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_word = '0; in_control = 1'b0;
    out_ready = 1'b1; clear_counts = 1'b0;
    #1;
    test_reset();
    test_clean();
    test_errors();
    test_backpressure();
    test_saturation();
    test_back_to_back_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
